// File: rtl/flow_pkg.sv
// Shared types and constants for the byte/word flow converters (8-to-16 packer, 16-to-8 splitter).
package flow_pkg;

  localparam int FLOW_BYTE_W = 8;
  localparam int FLOW_WORD_W = 16;
  localparam logic [FLOW_BYTE_W-1:0] FLOW_PAD_BYTE = 8'h00;

  typedef logic [FLOW_BYTE_W-1:0] flow_byte_t;
  typedef logic [FLOW_WORD_W-1:0] flow_word_t;

endpackage

// File: rtl/flow_out_stage.sv
// Registered valid/data output stage: loads a new item when free or being accepted,
// drops valid on accept, and clears synchronously when the converter is disabled.
module flow_out_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         dst_rdy,
  output logic         dst_val,
  output logic [W-1:0] dst_data,
  output logic         stall
);

  logic         val_q, val_d;
  logic [W-1:0] data_q, data_d;

  // Callers only assert load when the stage is empty or being accepted this cycle.
  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    if (clr) begin
      val_d  = 1'b0;
      data_d = '0;
    end else if (load) begin
      val_d  = 1'b1;
      data_d = load_data;
    end else if (val_q && dst_rdy) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

  assign dst_val  = val_q;
  assign dst_data = data_q;
  assign stall    = val_q & ~dst_rdy;

endmodule

// File: rtl/flow_8to16.sv
// Packs a valid/ready byte stream into a valid/ready word stream, two bytes per word.
// Optional FLOW_8TO16_FLUSH_EN adds src_last/dst_pad to emit a padded half word.
module flow_8to16
  import flow_pkg::*;
#(
  parameter int IN_W      = FLOW_BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              src_val,
  output logic              src_rdy,
  input  logic [IN_W-1:0]   src_data,
`ifdef FLOW_8TO16_FLUSH_EN
  input  logic              src_last,
  output logic              dst_pad,
`endif
  output logic              dst_val,
  input  logic              dst_rdy,
  output logic [2*IN_W-1:0] dst_data
);

  localparam int OUT_W = 2 * IN_W;
`ifdef FLOW_8TO16_FLUSH_EN
  localparam int OW = OUT_W + 1;
`else
  localparam int OW = OUT_W;
`endif

  logic              hold_vld_q, hold_vld_d;
  logic [IN_W-1:0]   hold_data_q, hold_data_d;
  logic              src_acc;
  logic              complete;
  logic              out_stall;
  logic [IN_W-1:0]   first_byte, second_byte;
  logic [OUT_W-1:0]  word;
  logic [OW-1:0]     load_data;
  logic [OW-1:0]     out_data;

`ifdef FLOW_8TO16_FLUSH_EN
  assign src_rdy  = cfg_en & ~rst & ~(hold_vld_q & out_stall) & ~(src_last & out_stall);
  assign src_acc  = src_val & src_rdy;
  assign complete = src_acc & (hold_vld_q | src_last);
`else
  assign src_rdy  = cfg_en & ~rst & ~(hold_vld_q & out_stall);
  assign src_acc  = src_val & src_rdy;
  assign complete = src_acc & hold_vld_q;
`endif

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (!cfg_en) begin
      hold_vld_d = 1'b0;
    end else if (src_acc) begin
      if (complete) begin
        hold_vld_d = 1'b0;
      end else begin
        hold_vld_d  = 1'b1;
        hold_data_d = src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  // A flush with nothing held makes the incoming byte the first half and pads the second.
  always_comb begin
`ifdef FLOW_8TO16_FLUSH_EN
    first_byte  = hold_vld_q ? hold_data_q : src_data;
    second_byte = hold_vld_q ? src_data : IN_W'(FLOW_PAD_BYTE);
`else
    first_byte  = hold_data_q;
    second_byte = src_data;
`endif
    word = LSB_FIRST ? {second_byte, first_byte} : {first_byte, second_byte};
  end

`ifdef FLOW_8TO16_FLUSH_EN
  assign load_data = {~hold_vld_q, word};
`else
  assign load_data = word;
`endif

  flow_out_stage #(
    .W (OW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .clr       (~cfg_en),
    .load      (complete),
    .load_data (load_data),
    .dst_rdy   (dst_rdy),
    .dst_val   (dst_val),
    .dst_data  (out_data),
    .stall     (out_stall)
  );

  assign dst_data = out_data[OUT_W-1:0];
`ifdef FLOW_8TO16_FLUSH_EN
  assign dst_pad  = out_data[OUT_W];
`endif

endmodule

// File: tb/tb_flow_8to16.sv
// Directed self-checking bench for flow_8to16: one LSB-first and one MSB-first instance
// share the same stimulus; FLOW_8TO16_FLUSH_EN enables the flush vectors.
module tb_flow_8to16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        src_val;
  logic [7:0]  src_data;
  logic        dst_rdy;
  logic        src_rdy_l, src_rdy_m;
  logic        dst_val_l, dst_val_m;
  logic [15:0] dst_data_l, dst_data_m;
`ifdef FLOW_8TO16_FLUSH_EN
  logic        src_last;
  logic        dst_pad_l, dst_pad_m;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flow_8to16 #(.IN_W(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .src_val  (src_val),
    .src_rdy  (src_rdy_l),
    .src_data (src_data),
`ifdef FLOW_8TO16_FLUSH_EN
    .src_last (src_last),
    .dst_pad  (dst_pad_l),
`endif
    .dst_val  (dst_val_l),
    .dst_rdy  (dst_rdy),
    .dst_data (dst_data_l)
  );

  flow_8to16 #(.IN_W(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .src_val  (src_val),
    .src_rdy  (src_rdy_m),
    .src_data (src_data),
`ifdef FLOW_8TO16_FLUSH_EN
    .src_last (src_last),
    .dst_pad  (dst_pad_m),
`endif
    .dst_val  (dst_val_m),
    .dst_rdy  (dst_rdy),
    .dst_data (dst_data_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    cfg_en   = 1'b1;
    src_val  = 1'b0;
    src_data = 8'h00;
    dst_rdy  = 1'b1;
`ifdef FLOW_8TO16_FLUSH_EN
    src_last = 1'b0;
`endif
    cyc();
    cyc();
    smp();
    chk("rst_dst_val", 32'(dst_val_l), 32'h0);
    chk("rst_dst_data", 32'(dst_data_l), 32'h0);
    chk("rst_src_rdy", 32'(src_rdy_l), 32'h0);

    // basic pair, both byte orders
    cyc();
    rst      = 1'b0;
    src_val  = 1'b1;
    src_data = 8'h34;
    smp();
    chk("first_rdy", 32'(src_rdy_l), 32'h1);
    cyc();
    src_data = 8'h12;
    cyc();
    src_val = 1'b0;
    smp();
    chk("pair_val", 32'(dst_val_l), 32'h1);
    chk("pair_lsb", 32'(dst_data_l), 32'h1234);
    chk("pair_msb", 32'(dst_data_m), 32'h3412);
    cyc();
    smp();
    chk("pair_drain", 32'(dst_val_l), 32'h0);

    // continuous stream, words on alternate cycles
    cyc();
    for (int i = 1; i <= 8; i++) begin
      src_val  = 1'b1;
      src_data = 8'(i);
      smp();
      chk("strm_rdy", 32'(src_rdy_l), 32'h1);
      if (i >= 3 && (i % 2) == 1) begin
        chk("strm_val", 32'(dst_val_l), 32'h1);
        chk("strm_word", 32'(dst_data_l), 32'((((i - 1) & 8'hff) << 8) | (i - 2)));
      end else if (i >= 4) begin
        chk("strm_gap", 32'(dst_val_l), 32'h0);
      end
      cyc();
    end
    src_val = 1'b0;
    smp();
    chk("strm_last_val", 32'(dst_val_l), 32'h1);
    chk("strm_last_word", 32'(dst_data_l), 32'h0807);
    cyc();

    // output stall: one byte of slack, then refusal
    src_val  = 1'b1;
    src_data = 8'h01;
    cyc();
    src_data = 8'h02;
    cyc();
    dst_rdy  = 1'b0;
    src_data = 8'h03;
    smp();
    chk("stall_slack_rdy", 32'(src_rdy_l), 32'h1);
    cyc();
    src_data = 8'h04;
    smp();
    chk("stall_refuse_rdy", 32'(src_rdy_l), 32'h0);
    chk("stall_hold_word", 32'(dst_data_l), 32'h0201);
    cyc();
    smp();
    chk("stall_refuse_rdy2", 32'(src_rdy_l), 32'h0);
    chk("stall_hold_val", 32'(dst_val_l), 32'h1);
    chk("stall_hold_word2", 32'(dst_data_l), 32'h0201);
    cyc();
    dst_rdy = 1'b1;
    smp();
    chk("stall_release_rdy", 32'(src_rdy_l), 32'h1);
    cyc();
    src_val = 1'b0;
    smp();
    chk("stall_b2b_val", 32'(dst_val_l), 32'h1);
    chk("stall_b2b_word", 32'(dst_data_l), 32'h0403);
    cyc();

    // disable discards a held byte
    src_val  = 1'b1;
    src_data = 8'hAA;
    cyc();
    src_val = 1'b0;
    cfg_en  = 1'b0;
    smp();
    chk("dis_rdy", 32'(src_rdy_l), 32'h0);
    cyc();
    smp();
    chk("dis_data", 32'(dst_data_l), 32'h0);
    chk("dis_val", 32'(dst_val_l), 32'h0);
    cyc();
    cfg_en   = 1'b1;
    src_val  = 1'b1;
    src_data = 8'h11;
    cyc();
    src_data = 8'h22;
    cyc();
    src_val = 1'b0;
    smp();
    chk("reen_val", 32'(dst_val_l), 32'h1);
    chk("reen_lsb", 32'(dst_data_l), 32'h2211);
    chk("reen_msb", 32'(dst_data_m), 32'h1122);
    cyc();

    // reset with a word pending and a byte held
    dst_rdy  = 1'b0;
    src_val  = 1'b1;
    src_data = 8'h55;
    cyc();
    src_data = 8'h66;
    cyc();
    src_data = 8'h77;
    smp();
    chk("pend_word", 32'(dst_data_l), 32'h6655);
    cyc();
    src_val = 1'b0;
    rst     = 1'b1;
    cyc();
    smp();
    chk("mrst_val", 32'(dst_val_l), 32'h0);
    chk("mrst_data", 32'(dst_data_l), 32'h0);
    chk("mrst_rdy", 32'(src_rdy_l), 32'h0);
    cyc();
    rst      = 1'b0;
    dst_rdy  = 1'b1;
    src_val  = 1'b1;
    src_data = 8'h88;
    smp();
    chk("post_rst_rdy", 32'(src_rdy_l), 32'h1);
    cyc();
    src_data = 8'h99;
    cyc();
    src_val = 1'b0;
    smp();
    chk("post_rst_val", 32'(dst_val_l), 32'h1);
    chk("post_rst_word", 32'(dst_data_l), 32'h9988);
    cyc();

`ifdef FLOW_8TO16_FLUSH_EN
    src_val  = 1'b1;
    src_last = 1'b1;
    src_data = 8'h5A;
    smp();
    chk("flush_rdy", 32'(src_rdy_l), 32'h1);
    cyc();
    src_val  = 1'b0;
    src_last = 1'b0;
    smp();
    chk("flush_val", 32'(dst_val_l), 32'h1);
    chk("flush_lsb", 32'(dst_data_l), 32'h005A);
    chk("flush_msb", 32'(dst_data_m), 32'h5A00);
    chk("flush_pad", 32'(dst_pad_l), 32'h1);
    cyc();
    src_val  = 1'b1;
    src_data = 8'h01;
    cyc();
    src_last = 1'b1;
    src_data = 8'h02;
    cyc();
    src_val  = 1'b0;
    src_last = 1'b0;
    smp();
    chk("flush_pair_word", 32'(dst_data_l), 32'h0201);
    chk("flush_pair_pad", 32'(dst_pad_l), 32'h0);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
